// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-wide data memory serving the core's
// D-memory port. One request in flight at a time; each request completes
// with a single-cycle registered mem_ready pulse LATENCY cycles after it was
// accepted. Writes take priority over reads when both are requested.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WORDS = 1 << DEPTH_LOG2;
    // WAIT runs for LATENCY-1 cycles: it is entered with LATENCY-2 and exits on zero.
    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q;
    logic                    enter_resp;
    logic                    wr_en;
    logic                    rd_en;
    logic [31:0]             mem_q [WORDS];

    // Byte offset and high address bits play no part in word selection.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and capture logic; request inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    op_wr_d = mem_write;
                    idx_d   = mem_addr[DEPTH_LOG2+1:2];
                    wdata_d = mem_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: array access happens on the edge that enters RESP, using
    // the captured request (the _d view covers the LATENCY==1 direct path).
    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        wr_en      = enter_resp && op_wr_d && rst_n;
        rd_en      = enter_resp && !op_wr_d;
        rdata_d    = rd_en ? mem_q[idx_d] : rdata_q;
    end

    // Request capture, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= enter_resp;
        end
    end

    // Storage array; not reset, and a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the stimulus side predicts each
// response from a flat word-array model and queues it; a monitor on the
// falling edge pops and compares whenever a DUT raises mem_ready.
module tb_dmem_responder;

    localparam int LAT = 4;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        rd1, wr1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1;

    int          cyc = 0;
    logic        rst_smp = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] hold0 = 32'h0;
    logic [31:0] hold1 = 32'h0;
    bit [31:0]   mem_m [256];

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
        .mem_ready(ready1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare both DUTs against their queues once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (!rst_smp) begin
                q0.delete();
                q1.delete();
                hold0 = 32'h0;
                hold1 = 32'h0;
                chk("rst_ready0", {31'b0, mem_ready}, 32'd0);
                chk("rst_rdata0", mem_rdata, 32'd0);
                chk("rst_ready1", {31'b0, ready1}, 32'd0);
                chk("rst_rdata1", rdata1, 32'd0);
            end else begin
                if (mem_ready) begin
                    if (q0.size() == 0) begin
                        chk("ready0_spurious", {31'b0, mem_ready}, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        chk("ready0_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) hold0 = e.data;
                    end
                end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
                    e = q0.pop_front();
                    chk("ready0_missing", {31'b0, mem_ready}, 32'd1);
                    if (e.rd) hold0 = e.data;
                end
                chk("rdata0", mem_rdata, hold0);

                if (ready1) begin
                    if (q1.size() == 0) begin
                        chk("ready1_spurious", {31'b0, ready1}, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        chk("ready1_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) hold1 = e.data;
                    end
                end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                    e = q1.pop_front();
                    chk("ready1_missing", {31'b0, ready1}, 32'd1);
                    if (e.rd) hold1 = e.data;
                end
                chk("rdata1", rdata1, hold1);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the LATENCY=4 DUT and wait for its completion.
    // With alt set, address and write data are scrambled from cycle 2 onward.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit alt, input logic [31:0] a2);
        exp_t e;
        int   idx;
        idx    = int'((a / 4) % 256);
        e.cyc  = cyc + LAT;
        e.rd   = rd && !wr;
        e.data = mem_m[idx];
        if (wr) mem_m[idx] = d;
        q0.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        for (int n = 1; n <= LAT + 6; n++) begin
            tick();
            if (alt && n >= 2) begin
                mem_addr  = a2;
                mem_wdata = $urandom;
            end
            @(negedge clk);
            if (mem_ready) break;
        end
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr(input int idx);
        return ($urandom & 32'hFFFF_FC03) | (32'(idx) << 2);
    endfunction

    initial begin
        exp_t e;
        int   r;
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1; mem_read = 1'b0;
        tick();

        // Basic write then back-to-back read.
        req(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        req(1, 0, 32'h10, 32'h0, 0, 0);
        repeat (3) tick();

        // Address aliasing.
        req(0, 1, 32'h000, 32'h00000001, 0, 0);
        req(1, 0, 32'h400, 32'h0, 0, 0);
        req(1, 0, 32'h003, 32'h0, 0, 0);

        // Read/write collision resolves to a write.
        req(0, 1, 32'h40, 32'h77, 0, 0);
        req(1, 0, 32'h40, 32'h0, 0, 0);
        req(1, 1, 32'h20, 32'h55, 0, 0);
        req(1, 0, 32'h20, 32'h0, 0, 0);

        // Inputs changed while waiting are ignored.
        req(0, 1, 32'h10, 32'hA, 0, 0);
        req(0, 1, 32'h14, 32'hB, 0, 0);
        req(1, 0, 32'h10, 32'h0, 1, 32'h14);

        // Reset during an in-flight write discards it.
        req(0, 1, 32'h30, 32'h1234, 0, 0);
        mem_write = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hAAAA;
        tick(); tick();
        rst_n = 1'b0; mem_write = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        req(1, 0, 32'h30, 32'h0, 0, 0);

        // Randomized traffic over 16 aliased words.
        for (int i = 0; i < 16; i++) begin
            req(0, 1, rnd_addr(i), $urandom, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            req(r < 5 || r == 9, r >= 5, rnd_addr(int'($urandom_range(0, 15))), $urandom,
                bit'($urandom_range(0, 1)), rnd_addr(int'($urandom_range(0, 15))));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Minimum latency: write, then two back-to-back reads held high.
        e.rd = 1'b0; e.data = 32'h0; e.cyc = cyc + 1;
        q1.push_back(e);
        wr1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h5A5A;
        tick();
        wr1 = 1'b0;
        tick();
        e.rd = 1'b1; e.data = 32'h5A5A; e.cyc = cyc + 1;
        q1.push_back(e);
        e.cyc = cyc + 3;
        q1.push_back(e);
        rd1 = 1'b1;
        repeat (3) tick();
        rd1 = 1'b0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
